// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port between
//            the ALU writeback (req0) and the load writeback (req1); registers
//            the winner and drives a one-hot write-enable vector.
// Option   : RFARB_R0_DROP_EN - accepted writes to register 0 issue with
//            wr_en=0 and wr_valid=0 so $zero is never written.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   req0_valid,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,
    output logic [(1<<ADDR_W)-1:0] wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   wr_valid,
    output logic                   wr_src,
    output logic [15:0]            wr_count
);

    localparam int c_NREG = 1 << ADDR_W;

    logic                r_pri;
    logic [c_NREG-1:0]   r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_valid;
    logic                r_wr_src;
    logic [15:0]         r_wr_count;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt_any;
    logic                w_sel_src;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [c_NREG-1:0]   w_decode;
    logic                w_drop;

    // No grant while in reset, so a request coinciding with reset stays pending
    assign w_gnt0    = !reset && en && req0_valid && (!req1_valid || !r_pri);
    assign w_gnt1    = !reset && en && req1_valid && (!req0_valid ||  r_pri);
    assign w_gnt_any = w_gnt0 || w_gnt1;
    assign w_sel_src = w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        w_sel_addr = req0_addr;
        w_sel_data = req0_data;
        if (w_sel_src) begin
            w_sel_addr = req1_addr;
            w_sel_data = req1_data;
        end
    end

    always_comb begin
        w_decode             = '0;
        w_decode[w_sel_addr] = 1'b1;
    end

`ifdef RFARB_R0_DROP_EN
    assign w_drop = (w_sel_addr == '0);
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pri      <= 1'b0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_src   <= 1'b0;
            r_wr_count <= '0;
        end else if (w_gnt_any) begin
            r_pri      <= !w_sel_src;
            r_wr_addr  <= w_sel_addr;
            r_wr_data  <= w_sel_data;
            r_wr_src   <= w_sel_src;
            r_wr_valid <= !w_drop;
            r_wr_en    <= w_drop ? '0 : w_decode;
            r_wr_count <= r_wr_count + 16'd1;
        end else begin
            r_wr_valid <= 1'b0;
            r_wr_en    <= '0;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign wr_valid = r_wr_valid;
    assign wr_src   = r_wr_src;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Scoreboard bench for regfile_write_arbiter: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [31:0] wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_src;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_src     (wr_src),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic        src;
        logic [15:0] count;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the requester that did not win last has priority on a tie
    bit          m_last_win = 1'b1;
    exp_t        m_state = '{en: 32'd0, addr: 5'd0, data: 32'd0, valid: 1'b0, src: 1'b0, count: 16'd0};

    always @(negedge clk) begin
        bit   g;
        bit   w;
        exp_t nx;
        g = 1'b0;
        w = 1'b0;
        if (!reset && en) begin
            if (req0_valid && req1_valid) begin g = 1'b1; w = !m_last_win; end
            else if (req0_valid)          begin g = 1'b1; w = 1'b0; end
            else if (req1_valid)          begin g = 1'b1; w = 1'b1; end
        end
        chk("req0_ready", 64'(req0_ready), 64'(g && !w));
        chk("req1_ready", 64'(req1_ready), 64'(g &&  w));
        nx = m_state;
        if (reset) begin
            nx = '{en: 32'd0, addr: 5'd0, data: 32'd0, valid: 1'b0, src: 1'b0, count: 16'd0};
            m_last_win = 1'b1;
        end else if (g) begin
            bit drop;
            nx.addr  = w ? req1_addr : req0_addr;
            nx.data  = w ? req1_data : req0_data;
            nx.src   = w;
            nx.count = m_state.count + 16'd1;
`ifdef RFARB_R0_DROP_EN
            drop = (nx.addr == 5'd0);
`else
            drop = 1'b0;
`endif
            nx.valid = !drop;
            nx.en    = drop ? 32'd0 : (32'd1 << nx.addr);
            m_last_win = w;
        end else begin
            nx.valid = 1'b0;
            nx.en    = 32'd0;
        end
        m_state = nx;
        q.push_back(nx);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_valid", 64'(wr_valid), 64'(e.valid));
            chk("wr_en",    64'(wr_en),    64'(e.en));
            chk("wr_addr",  64'(wr_addr),  64'(e.addr));
            chk("wr_data",  64'(wr_data),  64'(e.data));
            chk("wr_src",   64'(wr_src),   64'(e.src));
            chk("wr_count", 64'(wr_count), 64'(e.count));
        end
    end

    task automatic cyc(input bit e, input bit r,
                       input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        en = e; reset = r;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit s0, s1;
        reset = 1'b1; en = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_count", 64'(wr_count), 64'd0);
        chk("idle_wr_en", 64'(wr_en), 64'd0);

        // Single requester
        cyc(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("single_wr_en",  64'(wr_en),   64'h20);
        chk("single_data",   64'(wr_data), 64'hDEADBEEF);
        chk("single_count",  64'(wr_count), 64'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Same address with priority on req1: 0x2 then 0x1
        cyc(1, 0, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
        chk("collide_first", 64'(wr_data), 64'h2);
        cyc(1, 0, 1, 5'd9, 32'h1, 0, 0, 0);
        chk("collide_second", 64'(wr_data), 64'h1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Contention from reset
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 5'd3, 32'h30 + i, 1, 5'd7, 32'h70 + i);
        chk("contend_count", 64'(wr_count), 64'd4);
        chk("contend_last_en", 64'(wr_en), 64'h80);

        // Enable off, then reset on the first enabled cycle
        cyc(1, 0, 1, 5'd2, 32'h22, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        cyc(1, 1, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        chk("rst_drop_valid", 64'(wr_valid), 64'd0);
        cyc(1, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        chk("after_rst_src", 64'(wr_src), 64'd0);
        chk("after_rst_addr", 64'(wr_addr), 64'd4);
        cyc(1, 0, 0, 0, 0, 1, 5'd6, 32'h66);

        // Address 0 from req1
        cyc(1, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF);
`ifdef RFARB_R0_DROP_EN
        chk("addr0_valid", 64'(wr_valid), 64'd0);
        chk("addr0_wr_en", 64'(wr_en), 64'd0);
`else
        chk("addr0_valid", 64'(wr_valid), 64'd1);
        chk("addr0_wr_en", 64'(wr_en), 64'd1);
`endif
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; requests are held until accepted
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            s0 = req0_ready;
            s1 = req1_ready;
            @(posedge clk);
            #2;
            if (!req0_valid || s0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
                req0_data  = $urandom;
            end
            if (!req1_valid || s1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
                req1_data  = $urandom;
            end
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 49) == 0);
        end

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", 64'(q.size() <= 1), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register-file write port between two writeback sources: requester 0 (ALU result) and requester 1 (memory load). Each cycle it accepts at most one write request, using round-robin arbitration. It registers the winning address and data, then drives a one-hot 32-bit write-enable vector, which it decodes internally from the 5-bit address. The block sits between the writeback muxes and the 32×32 register file, replacing the direct decoder drive.

## Interface

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (fixed; one-hot output is 2^ADDR_W wide)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  global enable; 0 blocks all grants (ready outputs forced 0)
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  5  requester 0 destination register
- req0_data  input  32  requester 0 write data
- req0_ready  output  1  requester 0 accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as above, for requester 1
- wr_en  output  32  registered one-hot write enable; bit i means write register i
- wr_addr  output  5  registered address of the current write
- wr_data  output  32  registered data of the current write
- wr_valid  output  1  registered; 1 when a write is presented this cycle
- wr_src  output  1  registered; index of the requester that owns the current write
- wr_count  output  16  number of writes issued since reset; wraps

## Operation

- State: the round-robin pointer `pri` (1 bit) and the output register stage.
- Grant logic is combinational, evaluated every cycle:
  - en=0: no grant.
  - Only reqK_valid=1: grant K.
  - Both valid: grant `pri`.
  - reqK_ready = (grant == K). No other backpressure; the register file always accepts.
- On a clock edge with a grant to K:
  - Output stage loads addr, data and wr_src=K.
  - wr_valid is set to 1.
  - wr_en is loaded with the one-hot decode of addr.
  - `pri` is set to !K.
  - wr_count increments.
- On a clock edge with no grant: wr_valid=0, wr_en=0. wr_addr, wr_data and wr_src hold their previous values. `pri` is unchanged.
- Both requesters target the same address in one cycle: they are serialized in grant order. The later grant's data is the final register contents.
- A requester must hold valid, addr and data stable until it sees ready. The arbiter does not sample a request without a grant.
- wr_count wraps from 0xFFFF to 0x0000.

## Timing

- Latency: a request granted in cycle t produces its write (wr_valid, wr_en) during cycle t+1, for exactly one cycle.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate.
- Reset, at a sampled posedge with reset=1:
  - wr_en=0, wr_valid=0, wr_addr=0, wr_data=0, wr_src=0, wr_count=0, pri=0.
  - Reset overrides any concurrent grant: that grant is lost and the requester keeps its request.
- Ready outputs are 0 during any cycle in which reset=1.
- en deasserting mid-stream: the write already registered still issues next cycle; no new grants are made.

## Configuration

- Macro `RFARB_R0_DROP_EN`.
- Defined:
  - A granted write to address 0 is accepted (ready=1, pri toggles, wr_count increments).
  - It issues with wr_en=0 and wr_valid=0, so register $zero is never written.
- Not defined: address-0 writes issue like any other, with wr_en bit 0 set. The register file must then suppress them itself.

## Test plan

- Reset then idle: after reset, all outputs 0. With no requests for 5 cycles, wr_valid=0, wr_en=0 and wr_count=0 throughout.
- Single requester:
  - Stimulus: req0 addr=5, data=0xDEADBEEF.
  - Response: req0_ready=1 the same cycle. Next cycle wr_valid=1, wr_en has only bit 5 set, wr_data=0xDEADBEEF, wr_src=0, and wr_count=1.
- Contention:
  - Stimulus: both valid from reset for 4 cycles; req0 addr=3, req1 addr=7.
  - Response: grants go 0,1,0,1. wr_en shows bit 3, 7, 3, 7 on successive cycles, and wr_count=4.
- Same-address collision:
  - Stimulus: req0 and req1 both target addr=9, data 0x1 and 0x2, with pri=1.
  - Response: 0x2 issues first, then 0x1.
- Enable and reset interaction:
  - Stimulus: en=0 with both valid for 3 cycles, then reset asserted in the cycle of the first grant.
  - Response: no readies while en=0. The granted request does not issue. After reset, pri=0 and req0 is granted first.
- Address 0 with `RFARB_R0_DROP_EN`:
  - Stimulus: req1 addr=0, data=0xFFFF.
  - Response, macro defined: ready=1, the next cycle has wr_en=0 and wr_valid=0, and wr_count still increments.
  - Response, macro undefined: wr_en bit 0 is set and wr_valid=1.
